// File: rtl/chi2_best_select.sv
// Chi-square sum-of-squares, cut and best-per-road selection with a
// first-word-fall-through output FIFO of track/marker records.
module chi2_best_select #(
  parameter int unsigned N_CHI      = 3,
  parameter int unsigned CHI_W      = 14,
  parameter int unsigned CHI2_W     = 23,
  parameter int unsigned MAP_W      = 5,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic                    IN_VALID,
  input  logic [N_CHI*CHI_W-1:0]  CHI,
  input  logic [MAP_W-1:0]        LCMAP,
  input  logic [MAP_W-1:0]        HITMAP,
  input  logic                    EC,
  input  logic                    EV,
  input  logic                    NOCUT,
  input  logic                    NOCOMP,
  input  logic [CHI2_W-1:0]       chi2cut_value,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [CHI2_W-1:0]       OUT_CHI2,
  output logic [MAP_W-1:0]        OUT_LCMAP,
  output logic [MAP_W-1:0]        OUT_HITMAP,
  output logic                    OUT_EE,
  output logic                    OUT_NOREC,
  output logic                    EMPTY,
  output logic                    FULL,
  output logic                    ALMOST_FULL,
  output logic                    OVERFLOW,
  output logic                    BEST_READY,
  output logic                    BETTER
);

  localparam int unsigned SQ_W  = 2 * CHI_W;
  localparam int unsigned SUM_W = SQ_W + $clog2(N_CHI + 1);
  localparam int unsigned REC_W = CHI2_W + 2 * MAP_W + 2;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned PC_W  = $clog2(MAP_W + 1);

  function automatic logic [PC_W-1:0] popcnt(input logic [MAP_W-1:0] m);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(MAP_W); i++) c = c + PC_W'(m[i]);
    return c;
  endfunction

  // S1: squares
  logic signed [SQ_W-1:0] ext [N_CHI];
  logic [SQ_W-1:0]        sq_d [N_CHI];
  logic [SQ_W-1:0]        sq1 [N_CHI];
  logic                   v1, ec1, ev1;
  logic [MAP_W-1:0]       lc1, hm1;

  always_comb begin
    for (int k = 0; k < int'(N_CHI); k++) begin
      ext[k]  = SQ_W'($signed(CHI[k*CHI_W +: CHI_W]));
      sq_d[k] = ext[k] * ext[k];
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      v1  <= 1'b0;
      ec1 <= 1'b0;
      ev1 <= 1'b0;
      lc1 <= '0;
      hm1 <= '0;
      for (int k = 0; k < int'(N_CHI); k++) sq1[k] <= '0;
    end else begin
      v1  <= IN_VALID;
      ec1 <= EC;
      ev1 <= EV;
      lc1 <= LCMAP;
      hm1 <= HITMAP;
      for (int k = 0; k < int'(N_CHI); k++) sq1[k] <= sq_d[k];
    end
  end

  // S2: saturating sum
  logic [SUM_W-1:0]  sum;
  logic [CHI2_W-1:0] chi2_d, chi2_2;
  logic              v2, ec2, ev2;
  logic [MAP_W-1:0]  lc2, hm2;

  always_comb begin
    sum = '0;
    for (int k = 0; k < int'(N_CHI); k++) sum = sum + SUM_W'(sq1[k]);
    chi2_d = (sum > SUM_W'({CHI2_W{1'b1}})) ? {CHI2_W{1'b1}} : sum[CHI2_W-1:0];
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      v2     <= 1'b0;
      ec2    <= 1'b0;
      ev2    <= 1'b0;
      lc2    <= '0;
      hm2    <= '0;
      chi2_2 <= '0;
    end else begin
      v2     <= v1;
      ec2    <= ec1;
      ev2    <= ev1;
      lc2    <= lc1;
      hm2    <= hm1;
      chi2_2 <= chi2_d;
    end
  end

  // S3: cut, best compare, record generation
  logic              best_v, best_v_d;
  logic [CHI2_W-1:0] best_chi2, best_chi2_d;
  logic [MAP_W-1:0]  best_lc, best_lc_d, best_hm, best_hm_d;
  logic              pass, replace, push, better, best_ready;
  logic              eb_v;
  logic [CHI2_W-1:0] eb_chi2;
  logic [MAP_W-1:0]  eb_lc, eb_hm;
  logic [REC_W-1:0]  push_rec, marker;

  assign marker = {{CHI2_W{1'b1}}, {MAP_W{1'b0}}, {MAP_W{1'b0}}, 1'b1, 1'b1};

  always_comb begin
    pass        = v2 && (NOCUT || (chi2_2 <= chi2cut_value));
    replace     = 1'b0;
    push        = 1'b0;
    push_rec    = '0;
    better      = 1'b0;
    best_ready  = 1'b0;
    best_v_d    = best_v;
    best_chi2_d = best_chi2;
    best_lc_d   = best_lc;
    best_hm_d   = best_hm;
    eb_v        = best_v;
    eb_chi2     = best_chi2;
    eb_lc       = best_lc;
    eb_hm       = best_hm;
    if (NOCOMP) begin
      best_v_d = 1'b0;
      if (pass) begin
        push       = 1'b1;
        push_rec   = {chi2_2, lc2, hm2, ev2, 1'b0};
        best_ready = 1'b1;
      end else if (v2 && ev2) begin
        push     = 1'b1;
        push_rec = marker;
      end
    end else begin
      // Strict comparisons keep the earlier candidate on a full tie
      replace = pass && (!best_v || (chi2_2 < best_chi2) ||
                ((chi2_2 == best_chi2) && (popcnt(hm2) > popcnt(best_hm))));
      better  = replace;
      if (replace) begin
        eb_v    = 1'b1;
        eb_chi2 = chi2_2;
        eb_lc   = lc2;
        eb_hm   = hm2;
      end
      if (v2 && (ec2 || ev2)) begin
        best_v_d = 1'b0;
        if (eb_v) begin
          push       = 1'b1;
          push_rec   = {eb_chi2, eb_lc, eb_hm, ev2, 1'b0};
          best_ready = 1'b1;
        end else if (ev2) begin
          push     = 1'b1;
          push_rec = marker;
        end
      end else if (replace) begin
        best_v_d    = 1'b1;
        best_chi2_d = chi2_2;
        best_lc_d   = lc2;
        best_hm_d   = hm2;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      best_v    <= 1'b0;
      best_chi2 <= '0;
      best_lc   <= '0;
      best_hm   <= '0;
    end else begin
      best_v    <= best_v_d;
      best_chi2 <= best_chi2_d;
      best_lc   <= best_lc_d;
      best_hm   <= best_hm_d;
    end
  end

  assign BETTER     = better;
  assign BEST_READY = best_ready;

  // Output FIFO
  logic [REC_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count;
  logic             pop, push_ok;
  logic [REC_W-1:0] head;

  assign EMPTY       = (count == '0);
  assign OUT_VALID   = !EMPTY;
  assign FULL        = (count == CNT_W'(FIFO_DEPTH));
  assign ALMOST_FULL = (count >= CNT_W'(FIFO_DEPTH - 3));
  assign pop         = OUT_VALID && OUT_READY;
  assign push_ok     = push && (!FULL || pop);

  always_ff @(posedge CLOCK) begin
    if (push_ok) mem[wptr] <= push_rec;
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
      if (push && !push_ok) OVERFLOW <= 1'b1;
    end
  end

  assign head = EMPTY ? '0 : mem[rptr];
  assign {OUT_CHI2, OUT_LCMAP, OUT_HITMAP, OUT_EE, OUT_NOREC} = head;

endmodule

// File: tb/tb_chi2_best_select.sv
// Scoreboard bench for chi2_best_select: directed roads/events, expected records
// queued at stimulus time and compared by an independent output monitor.
module tb_chi2_best_select;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        IN_VALID;
  logic [41:0] CHI;
  logic [4:0]  LCMAP, HITMAP;
  logic        EC, EV, NOCUT, NOCOMP;
  logic [22:0] chi2cut_value;
  logic        OUT_VALID, OUT_READY;
  logic [22:0] OUT_CHI2;
  logic [4:0]  OUT_LCMAP, OUT_HITMAP;
  logic        OUT_EE, OUT_NOREC, EMPTY, FULL, ALMOST_FULL, OVERFLOW;
  logic        BEST_READY, BETTER;

  chi2_best_select dut (
    .CLOCK(CLOCK), .RESET(RESET), .IN_VALID(IN_VALID), .CHI(CHI),
    .LCMAP(LCMAP), .HITMAP(HITMAP), .EC(EC), .EV(EV), .NOCUT(NOCUT),
    .NOCOMP(NOCOMP), .chi2cut_value(chi2cut_value), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_CHI2(OUT_CHI2), .OUT_LCMAP(OUT_LCMAP),
    .OUT_HITMAP(OUT_HITMAP), .OUT_EE(OUT_EE), .OUT_NOREC(OUT_NOREC),
    .EMPTY(EMPTY), .FULL(FULL), .ALMOST_FULL(ALMOST_FULL), .OVERFLOW(OVERFLOW),
    .BEST_READY(BEST_READY), .BETTER(BETTER)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int failures = 0;
  int better_cnt = 0;
  int br_cnt = 0;
  logic [34:0] exp_q [$];

  function automatic logic [34:0] rec(input logic [22:0] c2, input logic [4:0] lc,
                                      input logic [4:0] hm, input logic ee,
                                      input logic nr);
    return {c2, lc, hm, ee, nr};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compares every popped record against the scoreboard head
  always @(negedge CLOCK) begin
    logic [34:0] act, e;
    if (BETTER) better_cnt++;
    if (BEST_READY) br_cnt++;
    if (RESET && OUT_VALID && OUT_READY) begin
      act = {OUT_CHI2, OUT_LCMAP, OUT_HITMAP, OUT_EE, OUT_NOREC};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_record actual=%0h required=none", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          failures++;
          $display("FAIL record actual=%0h required=%0h", act, e);
        end
      end
    end
  end

  task automatic send(input int c0, input int c1, input int c2, input logic [4:0] lc,
                      input logic [4:0] hm, input logic ec, input logic ev);
    @(posedge CLOCK); #1;
    IN_VALID = 1'b1;
    CHI      = {14'(c2), 14'(c1), 14'(c0)};
    LCMAP    = lc;
    HITMAP   = hm;
    EC       = ec;
    EV       = ev;
  endtask

  task automatic idle(input int n);
    @(posedge CLOCK); #1;
    IN_VALID = 1'b0;
    EC = 1'b0;
    EV = 1'b0;
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  task automatic wait_drain(input string name);
    bit done = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLOCK);
      if (exp_q.size() == 0 && EMPTY) begin
        done = 1;
        break;
      end
    end
    chk(name, {63'd0, done}, 64'd1);
  endtask

  int b0, r0;

  initial begin
    RESET = 1'b0; IN_VALID = 1'b0; CHI = '0; LCMAP = '0; HITMAP = '0;
    EC = 1'b0; EV = 1'b0; NOCUT = 1'b0; NOCOMP = 1'b0; chi2cut_value = 23'd10;
    OUT_READY = 1'b1;
    repeat (3) @(negedge CLOCK);
    chk("reset_empty", {63'd0, EMPTY}, 64'd1);
    chk("reset_outs", {OUT_VALID, FULL, ALMOST_FULL, OVERFLOW, BETTER, BEST_READY,
                       OUT_CHI2, OUT_LCMAP, OUT_HITMAP, OUT_EE, OUT_NOREC}, 64'd0);
    @(posedge CLOCK); #1;
    RESET = 1'b1;
    idle(2);

    // Road of three, best chi2 = 2 arrives last
    b0 = better_cnt; r0 = br_cnt;
    exp_q.push_back(rec(23'd2, 5'h03, 5'h0f, 1'b0, 1'b0));
    send(1, 1, 1, 5'h01, 5'h03, 1'b0, 1'b0);
    send(2, 0, 0, 5'h02, 5'h07, 1'b0, 1'b0);
    send(0, 1, 1, 5'h03, 5'h0f, 1'b1, 1'b0);
    idle(6);
    wait_drain("t1_drain");
    chk("t1_better", 64'(better_cnt - b0), 64'd2);
    chk("t1_best_ready", 64'(br_cnt - r0), 64'd1);

    // Everything cut, event end gives a marker only
    chi2cut_value = 23'd2;
    b0 = better_cnt; r0 = br_cnt;
    exp_q.push_back(rec(23'h7fffff, 5'h00, 5'h00, 1'b1, 1'b1));
    send(1, 1, 1, 5'h04, 5'h1f, 1'b0, 1'b0);
    send(1, 2, 0, 5'h05, 5'h1f, 1'b0, 1'b1);
    idle(6);
    wait_drain("t2_drain");
    chk("t2_best_ready", 64'(br_cnt - r0), 64'd0);
    chk("t2_better", 64'(better_cnt - b0), 64'd0);

    // Equal-chi2 ties broken on hit popcount
    chi2cut_value = 23'd10;
    b0 = better_cnt;
    exp_q.push_back(rec(23'd5, 5'h0b, 5'b11111, 1'b0, 1'b0));
    send(1, 2, 0, 5'h0a, 5'b11100, 1'b0, 1'b0);
    send(0, 1, 2, 5'h0b, 5'b11111, 1'b1, 1'b0);
    idle(6);
    wait_drain("t3a_drain");
    chk("t3a_better", 64'(better_cnt - b0), 64'd2);
    b0 = better_cnt;
    exp_q.push_back(rec(23'd5, 5'h0c, 5'b11100, 1'b1, 1'b0));
    send(1, 2, 0, 5'h0c, 5'b11100, 1'b0, 1'b0);
    send(2, 1, 0, 5'h0d, 5'b00111, 1'b0, 1'b1);
    idle(6);
    wait_drain("t3b_drain");
    chk("t3b_better", 64'(better_cnt - b0), 64'd1);

    // Saturation: passes only with NOCUT
    NOCUT = 1'b1;
    exp_q.push_back(rec(23'h7fffff, 5'h11, 5'h12, 1'b1, 1'b0));
    send(-8192, -8192, -8192, 5'h11, 5'h12, 1'b0, 1'b1);
    idle(6);
    wait_drain("t4a_drain");
    NOCUT = 1'b0; chi2cut_value = 23'h7ffffe;
    send(-8192, -8192, -8192, 5'h13, 5'h14, 1'b1, 1'b0);
    idle(6);
    wait_drain("t4b_drain");
    chk("t4b_empty", {63'd0, EMPTY}, 64'd1);

    // NOCOMP: every passing candidate forwarded, EC ignored
    NOCOMP = 1'b1; chi2cut_value = 23'd10;
    b0 = better_cnt; r0 = br_cnt;
    exp_q.push_back(rec(23'd3, 5'h01, 5'h01, 1'b0, 1'b0));
    exp_q.push_back(rec(23'd4, 5'h02, 5'h02, 1'b0, 1'b0));
    exp_q.push_back(rec(23'd2, 5'h03, 5'h03, 1'b0, 1'b0));
    exp_q.push_back(rec(23'd5, 5'h04, 5'h04, 1'b1, 1'b0));
    send(1, 1, 1, 5'h01, 5'h01, 1'b0, 1'b0);
    send(0, 2, 0, 5'h02, 5'h02, 1'b1, 1'b0);
    send(0, 1, 1, 5'h03, 5'h03, 1'b0, 1'b0);
    send(0, 1, 2, 5'h04, 5'h04, 1'b0, 1'b1);
    idle(6);
    wait_drain("t5_drain");
    chk("t5_best_ready", 64'(br_cnt - r0), 64'd4);
    chk("t5_better", 64'(better_cnt - b0), 64'd0);

    // FIFO fill, overflow, ordered drain
    NOCOMP = 1'b0;
    OUT_READY = 1'b0;
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(rec(23'd1, 5'(i), 5'(i), 1'b0, 1'b0));
      send(1, 0, 0, 5'(i), 5'(i), 1'b1, 1'b0);
    end
    idle(6);
    chk("t6_af_at12", {62'd0, ALMOST_FULL, FULL}, 64'd0);
    exp_q.push_back(rec(23'd1, 5'd12, 5'd12, 1'b0, 1'b0));
    send(1, 0, 0, 5'd12, 5'd12, 1'b1, 1'b0);
    idle(6);
    chk("t6_af_at13", {62'd0, ALMOST_FULL, FULL}, 64'd2);
    for (int i = 13; i < 16; i++) begin
      exp_q.push_back(rec(23'd1, 5'(i), 5'(i), 1'b0, 1'b0));
      send(1, 0, 0, 5'(i), 5'(i), 1'b1, 1'b0);
    end
    idle(6);
    chk("t6_full_at16", {62'd0, FULL, OVERFLOW}, 64'd2);
    send(1, 0, 0, 5'd16, 5'd16, 1'b1, 1'b0);
    idle(6);
    chk("t6_overflow", {62'd0, FULL, OVERFLOW}, 64'd3);
    OUT_READY = 1'b1;
    wait_drain("t6_drain");
    chk("t6_overflow_sticky", {63'd0, OVERFLOW}, 64'd1);

    // Reset mid-drain discards contents and clears OVERFLOW
    OUT_READY = 1'b0;
    for (int i = 20; i < 23; i++) begin
      exp_q.push_back(rec(23'd1, 5'(i), 5'(i), 1'b0, 1'b0));
      send(1, 0, 0, 5'(i), 5'(i), 1'b1, 1'b0);
    end
    idle(6);
    OUT_READY = 1'b1;
    @(posedge CLOCK); #1;
    OUT_READY = 1'b0;
    @(posedge CLOCK); #1;
    chk("t6_pre_reset_valid", {63'd0, OUT_VALID}, 64'd1);
    RESET = 1'b0;
    #1;
    chk("t6_reset_empty", {62'd0, EMPTY, OVERFLOW}, 64'd2);
    chk("t6_reset_data", {OUT_VALID, OUT_CHI2, OUT_LCMAP, OUT_HITMAP}, 64'd0);
    exp_q.delete();
    @(posedge CLOCK); #1;
    RESET = 1'b1;
    idle(4);
    chk("final_queue", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chi2_best_select.md
Name: chi2_best_select

Overview:
- Parametrised successor to the GigaFitter chi-square comparator.
- Takes per-combination fit residual components from the fitter core, forms chi2 as a sum of squares, applies the chi2 cut and keeps the best candidate per road.
- Writes best-per-road (or, in NOCOMP mode, every passing) records plus end-of-event markers into an output FIFO that feeds the track output formatter.

Parameters:
N_CHI, 3, number of residual components per fit
CHI_W, 14, width of each signed residual component
CHI2_W, 23, width of the chi2 value and of chi2cut_value
MAP_W, 5, width of LCMAP and HITMAP
FIFO_DEPTH, 16, output FIFO depth in records; power of 2, >= 8

Ports:
CLOCK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-low reset
IN_VALID  in  1  qualifies CHI, LCMAP, HITMAP, EC, EV
CHI  in  N_CHI*CHI_W  signed residuals, component k at bits [k*CHI_W +: CHI_W]
LCMAP  in  MAP_W  long-cluster map of the combination
HITMAP  in  MAP_W  hit map of the combination
EC  in  1  last combination of the current road
EV  in  1  last combination of the event; implies EC
NOCUT  in  1  bypass the chi2 cut
NOCOMP  in  1  forward every passing candidate, no best selection
chi2cut_value  in  CHI2_W  cut; candidate passes if chi2 <= chi2cut_value
OUT_VALID  out  1  FIFO head valid (equals !EMPTY)
OUT_READY  in  1  consumer pop; pop occurs when OUT_VALID && OUT_READY
OUT_CHI2  out  CHI2_W  record chi2
OUT_LCMAP  out  MAP_W  record LCMAP
OUT_HITMAP  out  MAP_W  record HITMAP
OUT_EE  out  1  record closes an event
OUT_NOREC  out  1  marker-only record, no track
EMPTY  out  1  FIFO empty
FULL  out  1  FIFO count == FIFO_DEPTH
ALMOST_FULL  out  1  FIFO count >= FIFO_DEPTH-3; upstream must stop IN_VALID
OVERFLOW  out  1  sticky: a push was dropped
BEST_READY  out  1  1-cycle pulse on every track-record push
BETTER  out  1  1-cycle pulse when a candidate becomes the road best

Behaviour:
Reset (RESET=0, asynchronous):
- Pipeline valids cleared, best register invalid, FIFO pointers and count zero, OVERFLOW cleared.
- EMPTY=1. All other outputs 0, data outputs included.
- Reset mid-operation discards in-flight candidates and all FIFO contents.

Pipeline (all signals travel with their valid bit):
- S1: square each component; unsigned, 2*CHI_W bits.
- S2: sum the squares; saturate to 2^CHI2_W-1 when the sum exceeds it.
- S3: cut decision, best compare, FIFO push.
- Latency: IN_VALID at cycle t gives BETTER/BEST_READY/push at edge t+3 and OUT_VALID at t+4 when the FIFO was empty.
- Full throughput, 1 combination per cycle.
- Cut: pass = NOCUT || (chi2 <= chi2cut_value). A saturated chi2 passes only with NOCUT.

Best select (NOCOMP=0), at S3 for a passing candidate:
- Replace the best when the best is invalid.
- Replace when chi2 < best.
- Replace on equal chi2 when popcount(HITMAP) > popcount(best HITMAP).
- Otherwise keep the existing best, so the earlier candidate wins a full tie.
- BETTER pulses on every replace.

Road close (EC or EV at S3), evaluated after the current candidate is included:
- Best valid: push {best, EE=EV, NOREC=0} and pulse BEST_READY.
- Best invalid and EV=1: push marker {chi2=all ones, maps=0, EE=1, NOREC=1}. No BEST_READY pulse.
- Best invalid and EV=0: no push.
- Best is cleared in every case.

NOCOMP=1:
- Every passing candidate is pushed immediately, with EE=EV.
- EC is ignored.
- EV on a failing candidate pushes a marker.
- BETTER stays 0.
- The best register is held invalid.

FIFO:
- First-word-fall-through; at most one push per cycle.
- Push while FULL is accepted only when a pop occurs in the same cycle.
- Otherwise the push is dropped and OVERFLOW sets; it stays set until reset.
- Records are popped in push order.

Mode inputs:
- NOCUT, NOCOMP and chi2cut_value are sampled at S3.
- Change them only between events.

Test Plan:
1. Road of 3 combinations, CHI=(1,1,1),(2,0,0),(0,1,1), EC on the third, cut=10 -> one record, OUT_CHI2=2, NOREC=0. BETTER pulses at t+3 and t+5. BEST_READY at t+5.
2. cut=2, combinations chi2=3 and 5, EV on the second -> single marker: OUT_CHI2=0x7FFFFF, EE=1, NOREC=1. BEST_READY never pulses.
3. Ties at chi2=5: HITMAP 11100 then 11111 -> the second is kept. HITMAP 11100 then 00111 -> the first is kept. BETTER counts are 2 and 1 respectively.
4. CHI=(-8192,-8192,-8192) saturates to 0x7FFFFF. NOCUT=1 -> record pushed. NOCUT=0, cut=0x7FFFFE -> no record.
5. NOCOMP=1, 4 passing combinations, EV on the fourth -> 4 records, EE set only on the fourth, 4 BEST_READY pulses, BETTER=0.
6. OUT_READY=0, 17 single-combination roads with EC -> ALMOST_FULL at count 13, FULL at 16, 17th dropped, OVERFLOW=1. Drain returns the 16 in order. Asserting RESET=0 mid-drain -> EMPTY=1 and OVERFLOW=0 immediately.
